matmul3x3_bus_regfile: RTL and testbench

- Bus-side register file and run sequencer for the 3x3 matrix-multiply core.
- Decodes single-word bus writes and reads, and holds the matrix M[0..8], the vector V[0..2] and the result Y[0..2].
- Launches the core through a start/done handshake.
- Produces the registered read response, a 33-bit valid+data word, that feeds the downstream bus read-single stage.

---
 rtl/matmul3x3_bus_regfile.sv | 211 +++++++++++++++++++++
 tb/tb_matmul3x3_bus_regfile.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul3x3_bus_regfile.sv
// Bus register file and run sequencer for the 3x3 matrix-multiply core.
// Holds M[0..8], V[0..2] and Y[0..2], decodes single-word bus accesses,
// returns a registered {valid, data} read response one cycle after bus_re,
// and launches the core through a start/done handshake.
// Optional feature: define MATMUL_BUS_IRQ_EN to add a sticky irq output
// that rises with done and falls when CTRL bit1 is written.
module matmul3x3_bus_regfile #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic            system1000,
    input  logic            system1000_rst,
    input  logic [AW-1:0]   bus_addr,
    input  logic [DW-1:0]   bus_wdata,
    input  logic            bus_we,
    input  logic            bus_re,
    output logic [DW:0]     rd_resp,
    output logic            core_start,
    output logic [9*DW-1:0] core_m,
    output logic [3*DW-1:0] core_v,
    input  logic            core_done,
    input  logic [3*DW-1:0] core_y
`ifdef MATMUL_BUS_IRQ_EN
    ,
    output logic            irq
`endif
);

    // Word-index map: M at 0..8, V at 9..11, CTRL 12, STATUS 13, Y at 14..16.
    localparam int IW = AW - 2;
    localparam logic [IW-1:0] IDX_V0     = IW'(9);
    localparam logic [IW-1:0] IDX_CTRL   = IW'(12);
    localparam logic [IW-1:0] IDX_STATUS = IW'(13);
    localparam logic [IW-1:0] IDX_Y0     = IW'(14);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [DW-1:0]   r_m [0:8];
    logic [DW-1:0]   r_v [0:2];
    logic [DW-1:0]   r_y [0:2];
    logic            r_done;
    logic            r_err;
    logic [DW:0]     r_rd_resp;

    logic [IW-1:0]   w_widx;
    logic            w_busy;
    logic            w_mv_sel;
    logic            w_ctrl_wr;
    logic            w_launch;
    logic            w_blocked_wr;
    logic            w_done_evt;
    logic [DW-1:0]   w_rdata;
    logic            w_unused_addr_lsb;

    // Byte-lane bits carry no meaning for word-wide registers.
    assign w_unused_addr_lsb = &{1'b0, bus_addr[1:0]};

    assign w_widx       = bus_addr[AW-1:2];
    assign w_busy       = (r_state != ST_IDLE);
    assign w_mv_sel     = (w_widx < IDX_CTRL);
    assign w_ctrl_wr    = bus_we && (w_widx == IDX_CTRL);
    assign w_launch     = w_ctrl_wr && bus_wdata[0] && !w_busy;
    // Anything that would disturb the operands of a running job is refused.
    assign w_blocked_wr = bus_we && w_busy && (w_mv_sel || (w_ctrl_wr && bus_wdata[0]));
    // core_done only counts while a job is actually running.
    assign w_done_evt   = (r_state == ST_RUN) && core_done;

    // FSM state register.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (system1000_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and launch pulse.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value unassigned (no latch).
        w_state_next = r_state;
        core_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                core_start   = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (core_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand registers (bus writable while idle) and result capture.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        // NOTE: this register file is small and must read as zero after reset, so every word is reset.
        if (system1000_rst) begin
            for (int k = 0; k < 9; k++) r_m[k] <= '0;
            for (int k = 0; k < 3; k++) r_v[k] <= '0;
            for (int k = 0; k < 3; k++) r_y[k] <= '0;
        end else begin
            if (bus_we && !w_busy && w_mv_sel) begin
                for (int k = 0; k < 9; k++) begin
                    if (w_widx == IW'(k)) r_m[k] <= bus_wdata;
                end
                for (int k = 0; k < 3; k++) begin
                    if (w_widx == IDX_V0 + IW'(k)) r_v[k] <= bus_wdata;
                end
            end
            if (w_done_evt) begin
                for (int k = 0; k < 3; k++) r_y[k] <= core_y[k*DW +: DW];
            end
        end
    end

    // Sticky done/err flags: clear first, then launch/err/done events (later assignments win).
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_ctrl_wr && bus_wdata[1]) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_launch) begin
                r_done <= 1'b0;
            end
            if (w_blocked_wr) begin
                r_err <= 1'b1;
            end
            if (w_done_evt) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef MATMUL_BUS_IRQ_EN
    logic r_irq;

    // Interrupt rises with done and holds until software clears it via CTRL bit1.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_irq <= 1'b0;
        end else begin
            if (w_ctrl_wr && bus_wdata[1]) begin
                r_irq <= 1'b0;
            end
            if (w_done_evt) begin
                r_irq <= 1'b1;
            end
        end
    end

    assign irq = r_irq;
`endif

    // Read data mux over the current (pre-write) register contents.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < 9; k++) begin
            if (w_widx == IW'(k)) w_rdata = r_m[k];
        end
        for (int k = 0; k < 3; k++) begin
            if (w_widx == IDX_V0 + IW'(k)) w_rdata = r_v[k];
            if (w_widx == IDX_Y0 + IW'(k)) w_rdata = r_y[k];
        end
        if (w_widx == IDX_STATUS) begin
            w_rdata = {{(DW-3){1'b0}}, r_err, r_done, w_busy};
        end
    end

    // Registered read response: {1, data} the cycle after bus_re, otherwise all zero.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_rd_resp <= '0;
        end else if (bus_re) begin
            r_rd_resp <= {1'b1, w_rdata};
        end else begin
            r_rd_resp <= '0;
        end
    end

    assign rd_resp = r_rd_resp;

    // Operands go straight to the core; bus writes are refused while busy, so they hold through RUN.
    for (genvar g = 0; g < 9; g++) begin : g_core_m
        assign core_m[g*DW +: DW] = r_m[g];
    end
    for (genvar g = 0; g < 3; g++) begin : g_core_v
        assign core_v[g*DW +: DW] = r_v[g];
    end

endmodule

// File: tb/tb_matmul3x3_bus_regfile.sv
// Scoreboard bench for matmul3x3_bus_regfile: a clocked reference model
// predicts read responses and launch pulses into queues, a monitor on the
// falling edge pops and compares, and a small core model answers core_start.
module tb_matmul3x3_bus_regfile;

    localparam int DW = 32;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   bus_addr  = '0;
    logic [DW-1:0]   bus_wdata = '0;
    logic            bus_we    = 1'b0;
    logic            bus_re    = 1'b0;
    logic [DW:0]     rd_resp;
    logic            core_start;
    logic [9*DW-1:0] core_m;
    logic [3*DW-1:0] core_v;
    logic            core_done = 1'b0;
    logic [3*DW-1:0] core_y    = '0;
`ifdef MATMUL_BUS_IRQ_EN
    logic            irq;
`endif

    always #5 clk = ~clk;

    matmul3x3_bus_regfile #(.DW(DW), .AW(AW)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_we         (bus_we),
        .bus_re         (bus_re),
        .rd_resp        (rd_resp),
        .core_start     (core_start),
        .core_m         (core_m),
        .core_v         (core_v),
        .core_done      (core_done),
        .core_y         (core_y)
`ifdef MATMUL_BUS_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [DW:0] data;
        int          cyc;
    } rd_exp_t;

    logic [31:0] mm [9];
    logic [31:0] mv [3];
    logic [31:0] my [3];
    bit          m_busy, m_done, m_err, m_irq;
    int          m_launch_cyc;
    int          cyc;
    int          m_idx;
    rd_exp_t     rq [$];
    int          sq [$];

    int          total = 0;
    int          bad   = 0;
    bit          core_auto = 1'b0;
    int          stray_cnt = 0;

    rd_exp_t     mon_e;
    bit          mon_exp_start;

    task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int idx);
        if (idx < 9)                      return mm[idx];
        else if (idx < 12)                return mv[idx-9];
        else if (idx == 13)               return {29'd0, m_err, m_done, m_busy};
        else if (idx >= 14 && idx <= 16)  return my[idx-14];
        else                              return 32'd0;
    endfunction

    function automatic logic [9*DW-1:0] pack_m();
        logic [9*DW-1:0] p;
        for (int k = 0; k < 9; k++) p[k*DW +: DW] = mm[k];
        return p;
    endfunction

    function automatic logic [9*DW-1:0] pack_v();
        logic [9*DW-1:0] p;
        p = '0;
        for (int k = 0; k < 3; k++) p[k*DW +: DW] = mv[k];
        return p;
    endfunction

    // Reference model: applies each bus access and core completion the way
    // the register map describes, predicting reads from the pre-edge contents.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) mm[k] = '0;
            for (int k = 0; k < 3; k++) begin mv[k] = '0; my[k] = '0; end
            m_busy = 0; m_done = 0; m_err = 0; m_irq = 0;
            m_launch_cyc = -100;
            rq.delete();
            sq.delete();
        end else begin
            m_idx = int'(bus_addr) / 4;
            if (bus_re) rq.push_back('{{1'b1, model_read(m_idx)}, cyc + 1});
            if (bus_we) begin
                if (m_idx < 12) begin
                    if (m_busy)          m_err = 1;
                    else if (m_idx < 9)  mm[m_idx] = bus_wdata;
                    else                 mv[m_idx-9] = bus_wdata;
                end else if (m_idx == 12) begin
                    if (bus_wdata[1]) begin m_done = 0; m_err = 0; m_irq = 0; end
                    if (bus_wdata[0]) begin
                        if (m_busy) m_err = 1;
                        else begin
                            m_done = 0;
                            m_busy = 1;
                            m_launch_cyc = cyc;
                            sq.push_back(cyc + 1);
                        end
                    end
                end
            end
            // A job is running from two edges after its launch until done.
            if (core_done && m_busy && cyc >= m_launch_cyc + 2) begin
                for (int k = 0; k < 3; k++) my[k] = core_y[k*DW +: DW];
                m_done = 1;
                m_irq  = 1;
                m_busy = 0;
            end
            cyc++;
        end
    end

    // Monitor: compares DUT outputs against the queued predictions.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_resp[DW]) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", rd_resp, '0);
                end else begin
                    mon_e = rq.pop_front();
                    check("rd_data", rd_resp, mon_e.data);
                    check("rd_cycle", cyc, mon_e.cyc);
                end
            end else begin
                check("rd_idle", rd_resp, '0);
                if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                    check("rd_missing", rd_resp[DW], 1'b1);
                    void'(rq.pop_front());
                end
            end
            mon_exp_start = (sq.size() > 0) && (sq[0] == cyc);
            check("core_start", core_start, mon_exp_start);
            if (mon_exp_start) begin
                void'(sq.pop_front());
                check("core_m", core_m, pack_m());
                check("core_v", core_v, pack_v());
            end
`ifdef MATMUL_BUS_IRQ_EN
            check("irq", irq, m_irq);
`endif
        end
    end

    // Core model: answers a launch with the wrapped product M*V four cycles later;
    // also emits an unsolicited done when the stimulus asks for one.
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (stray_cnt != seen) begin
                seen = stray_cnt;
                @(posedge clk); #1;
                core_y    = {$urandom, $urandom, $urandom};
                core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
            end else if (core_start && core_auto && !rst) begin
                repeat (4) @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++)
                    core_y[i*DW +: DW] = mm[3*i]*mv[0] + mm[3*i+1]*mv[1] + mm[3*i+2]*mv[2];
                core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input bit we, input bit re, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus(1'b0, 1'b1, a, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin idle(1); n++; end
        total++;
        if (m_busy) begin
            bad++;
            $display("FAIL wait_idle: no core completion within %0d cycles", budget);
        end
    endtask

    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    bit            r_we, r_re;

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset contents, including an unmapped address.
        rd(8'h00); rd(8'h34); rd(8'h38); rd(8'h7C);
        idle(2);

        // Identity matrix, V = {5,7,9}, launch and poll.
        core_auto = 1'b1;
        wr(8'h00, 1); wr(8'h10, 1); wr(8'h20, 1);
        wr(8'h24, 5); wr(8'h28, 7); wr(8'h2C, 9);
        wr(8'h30, 1);
        rd(8'h34); rd(8'h34);
        wait_idle(30);
        rd(8'h34); rd(8'h38); rd(8'h3C); rd(8'h40);
        idle(2);

        // Writes while busy are refused and flag err.
        wr(8'h30, 1);
        idle(1);
        wr(8'h00, 32'hFFFF_FFFF);
        wr(8'h30, 1);
        rd(8'h00); rd(8'h34);
        wait_idle(30);
        rd(8'h34);
        wr(8'h30, 2);
        rd(8'h34);

        // Same-cycle write and read to V[1].
        bus(1'b1, 1'b1, 8'h28, 32'hA5A5_A5A5);
        rd(8'h28);
        idle(2);

        // Randomised traffic, mostly on mapped words.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 85) r_a = AW'(4 * $urandom_range(0, 18));
            else                            r_a = AW'($urandom);
            r_we = ($urandom_range(0, 3) == 0);
            r_re = ($urandom_range(0, 1) == 1);
            if (r_a[AW-1:2] == 6'd12) begin
                r_d = DW'($urandom_range(0, 3));
                if (m_busy && r_d == 3) r_d = 2;
            end else begin
                r_d = $urandom;
            end
            bus(r_we, r_re, r_a, r_d);
        end
        wait_idle(30);
        for (int k = 0; k < 17; k++) rd(AW'(4 * k));
        idle(2);

        // Reset in the middle of a run, then a stray core_done.
        core_auto = 1'b0;
        wr(8'h30, 1);
        idle(3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        stray_cnt++;
        idle(4);
        rd(8'h38); rd(8'h3C); rd(8'h40); rd(8'h34); rd(8'h00);
        idle(4);

        check("rd_drain", rq.size(), 0);
        check("start_drain", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
